crc3_serial_tx: RTL and testbench

Transmit-side partner of the serial CRC-3 checker on the serial link.
- Accepts a parallel message word, shifts it out MSB first, then appends the 3-bit CRC remainder for generator G(x)=x^3+x+1 (binary 1011).
- A frame passed unmodified to the checker, which is cleared before the frame, leaves that checker with a zero remainder and ERROR=0.
- Sits between the host-side message source and the serial link.

---
 rtl/crc3_serial_tx.sv | 129 ++++++++++++
 tb/tb_crc3_serial_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/crc3_serial_tx.sv
// Serial CRC-3 (G = x^3+x+1) frame transmitter: message MSB first, then remainder Q2,Q1,Q0.
// Optional CRC3_TX_INJECT_ERR_EN adds inject_err, which inverts the final CRC bit of a frame.
module crc3_serial_tx #(
    parameter int unsigned MSG_WIDTH = 8
) (
    input  logic                 GCLK,
    input  logic                 CLEAR_bar,
    input  logic                 start,
    input  logic [MSG_WIDTH-1:0] msg_in,
`ifdef CRC3_TX_INJECT_ERR_EN
    input  logic                 inject_err,
`endif
    output logic                 ready,
    output logic                 serial_out,
    output logic                 frame_valid,
    output logic                 done,
    output logic [2:0]           crc_out
);

    localparam int unsigned CNT_W = ($clog2(MSG_WIDTH) < 2) ? 2 : $clog2(MSG_WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] CRC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state_q, state_n;
    logic [MSG_WIDTH-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [2:0]           lfsr_q, lfsr_n;
    logic [2:0]           lfsr_step;
    logic                 inj_q, inj_n;
    logic                 fb;
    logic                 ready_n, serial_n, frame_valid_n, done_n;
    logic [2:0]           crc_n;

    // State and datapath registers; outputs are registered copies of next-state decodes.
    always_ff @(posedge GCLK or negedge CLEAR_bar) begin
        if (!CLEAR_bar) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            lfsr_q      <= '0;
            inj_q       <= 1'b0;
            ready       <= 1'b1;
            serial_out  <= 1'b0;
            frame_valid <= 1'b0;
            done        <= 1'b0;
            crc_out     <= 3'b000;
        end else begin
            state_q     <= state_n;
            shift_q     <= shift_n;
            cnt_q       <= cnt_n;
            lfsr_q      <= lfsr_n;
            inj_q       <= inj_n;
            ready       <= ready_n;
            serial_out  <= serial_n;
            frame_valid <= frame_valid_n;
            done        <= done_n;
            crc_out     <= crc_n;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        cnt_n     = cnt_q;
        lfsr_n    = lfsr_q;
        inj_n     = inj_q;
        crc_n     = crc_out;
        fb        = shift_q[MSG_WIDTH-1] ^ lfsr_q[2];
        lfsr_step = {lfsr_q[1], lfsr_q[0] ^ fb, fb};

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_n = msg_in;
                    lfsr_n  = 3'b000;
                    cnt_n   = CNT_W'(MSG_WIDTH - 1);
`ifdef CRC3_TX_INJECT_ERR_EN
                    inj_n   = inject_err;
`else
                    inj_n   = 1'b0;
`endif
                    state_n = DATA;
                end
            end
            DATA: begin
                lfsr_n  = lfsr_step;
                shift_n = shift_q << 1;
                if (cnt_q == '0) begin
                    cnt_n   = CNT_W'(2);
                    crc_n   = lfsr_step;
                    state_n = CRC;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            CRC: begin
                // Flush the remainder out of Q2 with no feedback.
                lfsr_n = {lfsr_q[1:0], 1'b0};
                if (cnt_q == '0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n       = (state_n == IDLE);
        frame_valid_n = (state_n == DATA) || (state_n == CRC);
        done_n        = (state_n == DONE);
        serial_n      = 1'b0;
        if (state_n == DATA) begin
            serial_n = shift_n[MSG_WIDTH-1];
        end else if (state_n == CRC) begin
            // The Q0 slot is the one with the counter at zero.
            serial_n = lfsr_n[2] ^ (inj_n && (cnt_n == '0));
        end
    end

endmodule

// File: tb/tb_crc3_serial_tx.sv
// Self-checking bench for crc3_serial_tx: directed and random frames against a polynomial-division model.
module tb_crc3_serial_tx;

    localparam int unsigned W = 8;

    logic         GCLK = 1'b0;
    logic         CLEAR_bar;
    logic         start;
    logic [W-1:0] msg_in;
`ifdef CRC3_TX_INJECT_ERR_EN
    logic         inject_err = 1'b0;
`endif
    logic         ready;
    logic         serial_out;
    logic         frame_valid;
    logic         done;
    logic [2:0]   crc_out;

    int compared   = 0;
    int mismatched = 0;

    crc3_serial_tx #(.MSG_WIDTH(W)) dut (
        .GCLK        (GCLK),
        .CLEAR_bar   (CLEAR_bar),
        .start       (start),
        .msg_in      (msg_in),
`ifdef CRC3_TX_INJECT_ERR_EN
        .inject_err  (inject_err),
`endif
        .ready       (ready),
        .serial_out  (serial_out),
        .frame_valid (frame_valid),
        .done        (done),
        .crc_out     (crc_out)
    );

    always #5 GCLK = ~GCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Remainder of an n-bit polynomial (MSB = highest power) modulo x^3+x+1, by long division.
    function automatic logic [2:0] poly_mod(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = v;
        for (int i = n - 1; i >= 3; i--) begin
            if (r[i]) r = r ^ (64'hB << (i - 3));
        end
        return r[2:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_frame(input logic [W-1:0] msg, input logic inj, input bit hold, input bit glitch);
        logic [63:0] rx;
        logic [63:0] frame_exp;
        logic [2:0]  crc_exp;
        rx        = '0;
        crc_exp   = poly_mod(64'(msg) << 3, W + 3);
        frame_exp = (64'(msg) << 3) | 64'(crc_exp ^ {2'b00, inj});
        start     = 1'b1;
        msg_in    = msg;
`ifdef CRC3_TX_INJECT_ERR_EN
        inject_err = inj;
`endif
        for (int i = 0; i < int'(W) + 3; i++) begin
            @(negedge GCLK);
            check("frame_valid", 64'(frame_valid), 64'd1);
            rx = (rx << 1) | 64'(serial_out);
            if (i == int'(W)) check("crc_out_first_crc_cycle", 64'(crc_out), 64'(crc_exp));
            if (!hold) start = glitch;
            if (glitch) begin
                msg_in = ~msg;
`ifdef CRC3_TX_INJECT_ERR_EN
                inject_err = ~inj;
`endif
            end
        end
        check("frame_bits", rx, frame_exp);
        check("loopback_error", 64'(poly_mod(rx, W + 3) != 3'b000), 64'(inj));
        @(negedge GCLK);
        check("done_pulse", 64'(done), 64'd1);
        check("done_valid_low", 64'(frame_valid), 64'd0);
        check("done_serial_low", 64'(serial_out), 64'd0);
        check("done_ready_low", 64'(ready), 64'd0);
        check("crc_out_done", 64'(crc_out), 64'(crc_exp));
        if (!hold) start = 1'b0;
        @(negedge GCLK);
        check("idle_ready", 64'(ready), 64'd1);
        check("idle_valid_low", 64'(frame_valid), 64'd0);
        check("idle_done_low", 64'(done), 64'd0);
        check("idle_serial_low", 64'(serial_out), 64'd0);
    endtask

    initial begin
        logic saw_done;
        logic saw_valid;
        CLEAR_bar = 1'b0;
        start     = 1'b0;
        msg_in    = '0;
        repeat (2) @(negedge GCLK);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_serial", 64'(serial_out), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_crc_out", 64'(crc_out), 64'd0);
        CLEAR_bar = 1'b1;
        @(negedge GCLK);
        check("post_rst_idle_valid", 64'(frame_valid), 64'd0);

        // Known vectors.
        run_frame(8'h01, 1'b0, 1'b0, 1'b0);
        check("crc_0x01", 64'(crc_out), 64'(3'b011));

        // Reset in the middle of DATA.
        start  = 1'b1;
        msg_in = 8'hA5;
        @(negedge GCLK);
        start = 1'b0;
        repeat (3) @(negedge GCLK);
        CLEAR_bar = 1'b0;
        #1;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_valid", 64'(frame_valid), 64'd0);
        check("midrst_serial", 64'(serial_out), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_crc_out", 64'(crc_out), 64'd0);
        @(negedge GCLK);
        CLEAR_bar = 1'b1;
        saw_done  = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge GCLK);
            saw_done  = saw_done | done;
            saw_valid = saw_valid | frame_valid;
        end
        check("midrst_no_done", 64'(saw_done), 64'd0);
        check("midrst_no_frame", 64'(saw_valid), 64'd0);
        check("midrst_ready_after", 64'(ready), 64'd1);

        run_frame(8'h02, 1'b0, 1'b0, 1'b0);
        check("crc_0x02", 64'(crc_out), 64'(3'b110));
        run_frame(8'h00, 1'b0, 1'b0, 1'b0);
        check("crc_0x00", 64'(crc_out), 64'(3'b000));

        // start and msg_in toggled during a frame must be ignored.
        run_frame(W'($urandom), 1'b0, 1'b0, 1'b1);
        run_frame(8'hFF, 1'b0, 1'b0, 1'b1);

        // start held high: back-to-back frames with a DONE + IDLE gap.
        run_frame(W'($urandom), 1'b0, 1'b1, 1'b0);
        run_frame(W'($urandom), 1'b0, 1'b1, 1'b0);
        run_frame(W'($urandom), 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 100; n++) begin
            run_frame(W'($urandom), 1'b0, 1'b0, 1'b0);
        end

`ifdef CRC3_TX_INJECT_ERR_EN
        run_frame(8'h01, 1'b1, 1'b0, 1'b0);
        check("inject_crc_out_true", 64'(crc_out), 64'(3'b011));
        run_frame(W'($urandom), 1'b1, 1'b0, 1'b0);
        run_frame(W'($urandom), 1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
